// File: rtl/tune_pkg.sv
// Shared types and reset constants for the tuning controller.
package tune_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    EVAL
  } state_e;

  localparam logic [25:0] PHASE_RST = 26'h1312eb;
  localparam logic [3:0]  GAIN_RST  = 4'd7;

endpackage

// File: rtl/rssi_avg.sv
// RSSI accumulator: sums 2^AVG_LOG2 accepted samples and exposes their mean.
module rssi_avg #(
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic       full,
  output logic [7:0] avg
);

  localparam int unsigned ACC_W = 8 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] CNT_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [AVG_LOG2:0] cnt_q, cnt_d;
  logic              take;

  assign take = en && sample_valid;
  // Asserted on the cycle the final sample is taken, so the caller can leave
  // MEASURE on that same edge.
  assign full = take && (cnt_q == CNT_LAST);
  assign avg  = acc_q[AVG_LOG2 +: 8];

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      acc_d = acc_q + ACC_W'(sample);
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tune_ctrl.sv
// Tuning controller: owns live phase_inc/gain, applies SPI config and runs an
// upward seek that settles, averages RSSI and stops on the first strong channel.
module tune_ctrl
  import tune_pkg::*;
#(
  parameter int unsigned PHASE_W       = 26,
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned AVG_LOG2      = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cfg_valid,
  input  logic [PHASE_W-1:0] cfg_phase_inc,
  input  logic [3:0]         cfg_gain,
  input  logic               seek_start,
  input  logic [PHASE_W-1:0] seek_step,
  input  logic [PHASE_W-1:0] seek_stop,
  input  logic [7:0]         seek_thresh,
  input  logic               rssi_valid,
  input  logic [7:0]         rssi,
  output logic [PHASE_W-1:0] phase_inc,
  output logic [3:0]         gain,
  output logic               retune,
  output logic               busy,
  output logic               done,
  output logic               found
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [3:0]         gain_q, gain_d;
  logic               retune_q, retune_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [PHASE_W-1:0] stop_q, stop_d;
  logic [7:0]         thresh_q, thresh_d;
  logic [PHASE_W-1:0] start_pi_q, start_pi_d;
  logic [CNT_W-1:0]   settle_q, settle_d;

  logic [PHASE_W:0]   next_pi;
  logic               avg_clr;
  logic               avg_full;
  logic [7:0]         avg;

  rssi_avg #(.AVG_LOG2(AVG_LOG2)) u_rssi_avg (
    .clk          (CLK),
    .rst          (RST),
    .clr          (avg_clr),
    .en           (state_q == MEASURE),
    .sample_valid (rssi_valid),
    .sample       (rssi),
    .full         (avg_full),
    .avg          (avg)
  );

  assign avg_clr = (state_q != MEASURE);
  assign next_pi = {1'b0, phase_q} + {1'b0, step_q};

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    gain_d     = gain_q;
    retune_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    found_d    = found_q;
    step_d     = step_q;
    stop_d     = stop_q;
    thresh_d   = thresh_q;
    start_pi_d = start_pi_q;
    settle_d   = '0;

    case (state_q)
      IDLE: begin
        if (seek_start) begin
          step_d     = seek_step;
          stop_d     = seek_stop;
          thresh_d   = seek_thresh;
          start_pi_d = phase_q;
          found_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = MEASURE;
        else                         settle_d = settle_q + 1'b1;
      end
      MEASURE: begin
        if (avg_full) state_d = EVAL;
      end
      EVAL: begin
        if (avg >= thresh_q) begin
          found_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (next_pi[PHASE_W] || (next_pi > {1'b0, stop_q}) || (step_q == '0)) begin
          phase_d  = start_pi_q;
          retune_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          phase_d  = next_pi[PHASE_W-1:0];
          retune_d = 1'b1;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Config wins in every state; restoring found_d undoes a same-cycle
    // seek_start in IDLE or a lock decided in EVAL.
    if (cfg_valid) begin
      phase_d  = cfg_phase_inc;
      gain_d   = cfg_gain;
      retune_d = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      found_d  = found_q;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      phase_q    <= PHASE_W'(PHASE_RST);
      gain_q     <= GAIN_RST;
      retune_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      step_q     <= '0;
      stop_q     <= '0;
      thresh_q   <= '0;
      start_pi_q <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      gain_q     <= gain_d;
      retune_q   <= retune_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      step_q     <= step_d;
      stop_q     <= stop_d;
      thresh_q   <= thresh_d;
      start_pi_q <= start_pi_d;
      settle_q   <= settle_d;
    end
  end

  assign phase_inc = phase_q;
  assign gain      = gain_q;
  assign retune    = retune_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;

endmodule
